load_rdata_unit: RTL and testbench

- Load-side counterpart of the store byte-lane write selector.
- Accepts a load request in the execute stage and selects the source: data memory, BIOS memory or memory-mapped I/O.
- One cycle later, extracts, aligns and sign/zero-extends the addressed byte, halfword or word for writeback.
- Owns the cycle and retired-instruction counters and generates the UART receive-pop strobe.

---
 rtl/load_rdata_unit.sv | 167 ++++++++++++++++
 tb/tb_load_rdata_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_rdata_unit.sv
// Load response path: source select, MMIO snapshot, byte/half/word extraction and counters.
// Optional misaligned-access detection is enabled by defining LOAD_MISALIGN_CHECK_EN.
module load_rdata_unit #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] dmem_dout,
  input  logic [31:0] bios_dout,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_tx_ready,
  input  logic        inst_retire,
  input  logic        counter_reset,
  output logic        uart_rx_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misaligned
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_DMEM, SRC_BIOS, SRC_MMIO} src_t;

  state_t               state;
  src_t                 req_src;
  src_t                 cap_src;
  logic [1:0]           cap_off;
  logic [2:0]           cap_f3;
  logic                 cap_mis;
  logic                 req_mis;
  logic [31:0]          snap;
  logic [31:0]          hold_word;
  logic [31:0]          mmio_word;
  logic [31:0]          raw_word;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] inst_cnt;
  logic                 capture;
  logic                 unused_addr;

  assign capture     = req_valid && !stall;
  assign unused_addr = ^{addr[29], addr[27:6]};

  always_comb begin
    if (addr[31])      req_src = SRC_MMIO;
    else if (addr[30]) req_src = SRC_BIOS;
    else if (addr[28]) req_src = SRC_DMEM;
    else               req_src = SRC_NONE;
  end

  always_comb begin
    mmio_word = '0;
    case (addr[5:2])
      4'h0:    mmio_word = {30'b0, uart_rx_valid, uart_tx_ready};
      4'h1:    mmio_word = {24'b0, uart_rx_data};
      4'h4:    mmio_word = 32'(cycle_cnt);
      4'h5:    mmio_word = 32'(inst_cnt);
      default: mmio_word = '0;
    endcase
  end

`ifdef LOAD_MISALIGN_CHECK_EN
  always_comb begin
    case (funct3)
      F3_LH, F3_LHU: req_mis = addr[0];
      F3_LW:         req_mis = |addr[1:0];
      default:       req_mis = 1'b0;
    endcase
  end
`else
  assign req_mis = 1'b0;
`endif

  // Pop is tied to the accepting cycle, so a stalled request cannot pop twice.
  assign uart_rx_ready = !rst && capture && (req_src == SRC_MMIO) &&
                         (addr[5:2] == 4'h1) && uart_rx_valid && !req_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cap_src   <= SRC_NONE;
      cap_off   <= '0;
      cap_f3    <= '0;
      cap_mis   <= 1'b0;
      snap      <= '0;
      hold_word <= '0;
    end else begin
      if (capture) begin
        cap_src <= req_src;
        cap_off <= addr[1:0];
        cap_f3  <= funct3;
        cap_mis <= req_mis;
        snap    <= mmio_word;
      end
      case (state)
        IDLE: if (capture) state <= RESP;
        RESP: begin
          if (stall) begin
            hold_word <= raw_word;
            state     <= HOLD;
          end else begin
            state <= capture ? RESP : IDLE;
          end
        end
        HOLD: if (!stall) state <= capture ? RESP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else if (counter_reset) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (inst_retire) inst_cnt <= inst_cnt + 1'b1;
    end
  end

  always_comb begin
    raw_word = '0;
    if (state == HOLD) begin
      raw_word = hold_word;
    end else begin
      case (cap_src)
        SRC_DMEM: raw_word = dmem_dout;
        SRC_BIOS: raw_word = bios_dout;
        SRC_MMIO: raw_word = snap;
        default:  raw_word = '0;
      endcase
    end
  end

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LBU:  return {24'b0, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LHU:  return {16'b0, h};
      F3_LW:   return w;
      default: return w;
    endcase
  endfunction

  assign rdata_valid = (state != IDLE);
  assign misaligned  = rdata_valid && cap_mis;
  assign rdata       = (rdata_valid && !cap_mis) ? extract(raw_word, cap_off, cap_f3) : '0;

endmodule

// File: tb/tb_load_rdata_unit.sv
// Directed self-checking bench for load_rdata_unit (32-bit and 8-bit counter instances).
module tb_load_rdata_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        stall;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [31:0] dmem_dout;
  logic [31:0] bios_dout;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_tx_ready;
  logic        inst_retire;
  logic        counter_reset;
  logic        uart_rx_ready, s_uart_rx_ready;
  logic [31:0] rdata, s_rdata;
  logic        rdata_valid, s_rdata_valid;
  logic        misaligned, s_misaligned;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  always #5 clk = ~clk;

  load_rdata_unit #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .stall(stall), .addr(addr), .funct3(funct3),
    .dmem_dout(dmem_dout), .bios_dout(bios_dout), .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data), .uart_tx_ready(uart_tx_ready), .inst_retire(inst_retire),
    .counter_reset(counter_reset), .uart_rx_ready(uart_rx_ready), .rdata(rdata),
    .rdata_valid(rdata_valid), .misaligned(misaligned)
  );

  load_rdata_unit #(.CNT_WIDTH(8)) u_small (
    .clk(clk), .rst(rst), .req_valid(req_valid), .stall(stall), .addr(addr), .funct3(funct3),
    .dmem_dout(dmem_dout), .bios_dout(bios_dout), .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data), .uart_tx_ready(uart_tx_ready), .inst_retire(inst_retire),
    .counter_reset(counter_reset), .uart_rx_ready(s_uart_rx_ready), .rdata(s_rdata),
    .rdata_valid(s_rdata_valid), .misaligned(s_misaligned)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated load: idle before, valid exactly one cycle after, idle again after that.
  task automatic load(input string tag, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] exp, input logic exp_mis);
    addr = a; funct3 = f; req_valid = 1'b1; stall = 1'b0;
    #1 check({tag, " pre_valid"}, 32'(rdata_valid), 32'd0);
    tick();
    req_valid = 1'b0;
    #1;
    check({tag, " valid"}, 32'(rdata_valid), 32'd1);
    check({tag, " rdata"}, rdata, exp);
    check({tag, " mis"}, 32'(misaligned), 32'(exp_mis));
    tick();
    #1 check({tag, " drop_valid"}, 32'(rdata_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; stall = 1'b0; addr = '0; funct3 = '0;
    dmem_dout = 32'h80FF7F01; bios_dout = 32'h1234F00D;
    uart_rx_valid = 1'b0; uart_rx_data = 8'h00; uart_tx_ready = 1'b0;
    inst_retire = 1'b0; counter_reset = 1'b0;
    #3;
    check("rst rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst misaligned", 32'(misaligned), 32'd0);
    check("rst uart_rx_ready", 32'(uart_rx_ready), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    load("dmem lb+1", 32'h10000005, LB, 32'h0000007F, 1'b0);
    load("dmem lb+2", 32'h10000006, LB, 32'hFFFFFFFF, 1'b0);
    load("dmem lbu+3", 32'h10000007, LBU, 32'h00000080, 1'b0);
    load("dmem lh+2", 32'h10000006, LH, 32'hFFFF80FF, 1'b0);
    load("dmem lhu+0", 32'h10000004, LHU, 32'h00007F01, 1'b0);
    load("dmem lw", 32'h10000004, LW, 32'h80FF7F01, 1'b0);
    load("dmem undef f3", 32'h10000005, 3'b011, 32'h80FF7F01, 1'b0);
    load("unmapped", 32'h00000004, LW, 32'h00000000, 1'b0);
    load("bios lb+1", 32'h40000001, LB, 32'hFFFFFFF0, 1'b0);
    load("bios lhu+2", 32'h40000002, LHU, 32'h00001234, 1'b0);

    // Back-to-back captures.
    addr = 32'h10000005; funct3 = LB; req_valid = 1'b1;
    tick();
    addr = 32'h10000007; funct3 = LBU;
    #1 check("b2b first", rdata, 32'h0000007F);
    tick();
    req_valid = 1'b0;
    #1;
    check("b2b second", rdata, 32'h00000080);
    check("b2b second valid", 32'(rdata_valid), 32'd1);
    tick();
    #1 check("b2b idle", 32'(rdata_valid), 32'd0);

    // Stall across the response while the BRAM output moves on.
    addr = 32'h10000004; funct3 = LW; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; stall = 1'b1;
    #1 check("stall c1 rdata", rdata, 32'h80FF7F01);
    tick();
    dmem_dout = 32'hDEADBEEF;
    #1;
    check("stall c2 rdata", rdata, 32'h80FF7F01);
    check("stall c2 valid", 32'(rdata_valid), 32'd1);
    tick();
    #1;
    check("stall c3 rdata", rdata, 32'h80FF7F01);
    check("stall c3 valid", 32'(rdata_valid), 32'd1);
    stall = 1'b0;
    #1 check("stall release rdata", rdata, 32'h80FF7F01);
    tick();
    #1 check("stall release idle", 32'(rdata_valid), 32'd0);
    dmem_dout = 32'h80FF7F01;

    // UART receive pop.
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A; uart_tx_ready = 1'b1;
    addr = 32'h80000004; funct3 = LBU; req_valid = 1'b1;
    #1 check("uart pop req", 32'(uart_rx_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
    check("uart pop after", 32'(uart_rx_ready), 32'd0);
    check("uart data", rdata, 32'h0000005A);
    tick();
    req_valid = 1'b1; stall = 1'b1;
    #1 check("uart stalled no pop", 32'(uart_rx_ready), 32'd0);
    tick();
    #1;
    check("uart stalled no pop2", 32'(uart_rx_ready), 32'd0);
    check("uart stalled no resp", 32'(rdata_valid), 32'd0);
    stall = 1'b0;
    #1 check("uart accepted pop", 32'(uart_rx_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
    check("uart accepted data", rdata, 32'h0000005A);
    check("uart single pulse", 32'(uart_rx_ready), 32'd0);
    tick();
    uart_tx_ready = 1'b0;
    load("mmio status", 32'h80000000, LW, 32'h00000002, 1'b0);
    uart_rx_valid = 1'b0; uart_tx_ready = 1'b1;
    load("mmio status2", 32'h80000000, LW, 32'h00000001, 1'b0);
    load("mmio unused", 32'h80000008, LW, 32'h00000000, 1'b0);
    uart_rx_valid = 1'b1;

    // Counters: clear, then 100 cycles with retire on even cycles.
    counter_reset = 1'b1;
    tick();
    counter_reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i % 2 == 0);
      tick();
    end
    inst_retire = 1'b0;
    addr = 32'h80000010; funct3 = LW; req_valid = 1'b1;
    tick();
    addr = 32'h80000014;
    #1 check("cycle count", rdata, 32'd100);
    tick();
    addr = 32'h80000010; counter_reset = 1'b1;
    #1 check("inst count", rdata, 32'd50);
    tick();
    counter_reset = 1'b0; inst_retire = 1'b1;
    #1 check("pre-clear snapshot", rdata, 32'd102);
    tick();
    addr = 32'h80000014; inst_retire = 1'b0;
    #1 check("post-clear cycle", rdata, 32'd0);
    tick();
    req_valid = 1'b0;
    #1 check("post-clear inst", rdata, 32'd1);
    tick();

    // Wrap on the 8-bit instance; zero-extension and no wrap on the 32-bit one.
    counter_reset = 1'b1;
    tick();
    counter_reset = 1'b0; inst_retire = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    addr = 32'h80000010; funct3 = LW; req_valid = 1'b1;
    tick();
    addr = 32'h80000014;
    #1;
    check("small cycle 255", s_rdata, 32'h000000FF);
    check("big cycle 255", rdata, 32'd255);
    tick();
    req_valid = 1'b0; inst_retire = 1'b0;
    #1;
    check("small inst wrap", s_rdata, 32'h00000000);
    check("small inst valid", 32'(s_rdata_valid), 32'd1);
    check("big inst 256", rdata, 32'd256);
    tick();
    addr = 32'h80000010; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    #1 check("small cycle wrapped", s_rdata, 32'd2);
    tick();

    // Misalignment handling.
`ifdef LOAD_MISALIGN_CHECK_EN
    load("mis lw", 32'h10000002, LW, 32'h00000000, 1'b1);
    load("mis lh", 32'h10000001, LH, 32'h00000000, 1'b1);
    addr = 32'h80000005; funct3 = LH; req_valid = 1'b1;
    #1 check("mis uart no pop", 32'(uart_rx_ready), 32'd0);
`else
    load("mis lw", 32'h10000002, LW, 32'h80FF7F01, 1'b0);
    load("mis lh", 32'h10000001, LH, 32'h00007F01, 1'b0);
    addr = 32'h80000005; funct3 = LH; req_valid = 1'b1;
    #1 check("mis uart pop", 32'(uart_rx_ready), 32'd1);
`endif
    tick();
    req_valid = 1'b0;
    tick();
    tick();

    // Asynchronous reset while holding a stalled response.
    addr = 32'h10000004; funct3 = LW; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; stall = 1'b1;
    tick();
    #1 check("hold before rst", 32'(rdata_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst valid", 32'(rdata_valid), 32'd0);
    check("async rst rdata", rdata, 32'd0);
    check("async rst mis", 32'(misaligned), 32'd0);
    tick(); tick();
    stall = 1'b0; rst = 1'b0;
    #1 check("rst release idle", 32'(rdata_valid), 32'd0);
    tick(); tick();
    addr = 32'h80000010; funct3 = LW; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    #1;
    check("cycle after rst", rdata, 32'd2);
    check("small cycle after rst", s_rdata, 32'd2);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
